// File: rtl/viterbi_frame_decoder.sv
// Hard-decision Viterbi frame decoder: one ACS step per accepted symbol, then traceback and bit-serial output.
// Latency FRAME_LEN+1 (terminated) or NS+FRAME_LEN+1 (best-state) after last symbol; input stalls outside IDLE/ACS, output holds while i_bit_ready=0.
module viterbi_frame_decoder #(
    parameter int             K         = 3,
    parameter int             N_OUT     = 2,
    parameter logic [K-1:0]   G0        = 3'b111,
    parameter logic [K-1:0]   G1        = 3'b101,
    parameter logic [K-1:0]   G2        = 3'b000,
    parameter int             FRAME_LEN = 16,
    parameter int             PM_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sym_valid,
    input  logic [N_OUT-1:0] i_sym,
    output logic             o_sym_ready,
    input  logic             i_tail_term,
    output logic             o_bit_valid,
    output logic             o_bit,
    input  logic             i_bit_ready,
    output logic             o_frame_done,
    output logic             o_busy
);
    localparam int NS   = 1 << (K - 1);
    localparam int CMAX = (FRAME_LEN > NS) ? FRAME_LEN : NS;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [CW-1:0]   ONE     = CW'(1);
    localparam logic [CW-1:0]   LAST    = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0]   FLEN    = CW'(FRAME_LEN);
    localparam logic [CW-1:0]   SLAST   = CW'(NS - 1);
    localparam logic [PM_W-1:0] PM_INIT = {1'b1, {(PM_W-1){1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACS   = 3'd1;
    localparam logic [2:0] S_BEST  = 3'd2;
    localparam logic [2:0] S_TRACE = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]      state;
    logic [CW-1:0]   cnt;
    logic            tail_q;
    logic [K-2:0]    tb_state;
    logic [PM_W-1:0] best_pm;
    logic [PM_W-1:0] pm      [NS];
    logic [PM_W-1:0] pm_nxt  [NS];
    logic [NS-1:0]   dec;
    logic [NS-1:0]   surv    [FRAME_LEN];
    logic [FRAME_LEN-1:0] out_buf;

    logic            sym_hs;
    logic            term;
    logic            scan_take;
    logic            trace_step;
    logic [K-2:0]    cnt_s;
    logic [TW-1:0]   cnt_t;
    logic [TW-1:0]   tr_t;

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
        logic [PM_W:0] s;
        s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
        return s[PM_W] ? {PM_W{1'b1}} : s[PM_W-1:0];
    endfunction

    // Hamming distance between the received symbol and the code bits of encoder register r.
    function automatic logic [1:0] bmetric(input logic [K-1:0] r, input logic [N_OUT-1:0] sym);
        logic [2:0] c;
        logic [2:0] d;
        c = {^(r & G2), ^(r & G1), ^(r & G0)};
        d = '0;
        d[N_OUT-1:0] = c[N_OUT-1:0] ^ sym;
        return {1'b0, d[0]} + {1'b0, d[1]} + {1'b0, d[2]};
    endfunction

    assign o_sym_ready  = rst && ((state == S_IDLE) || (state == S_ACS));
    assign sym_hs       = i_sym_valid && o_sym_ready;
    assign term         = (state == S_IDLE) ? i_tail_term : tail_q;
    assign cnt_s        = cnt[K-2:0];
    assign cnt_t        = cnt[TW-1:0];
    assign tr_t         = TW'(cnt - ONE);
    assign trace_step   = (state == S_TRACE) && (cnt != '0);
    assign scan_take    = (cnt == '0) || (pm[cnt_s] < best_pm);
    assign o_bit_valid  = (state == S_OUT);
    assign o_bit        = (state == S_OUT) ? out_buf[cnt_t] : 1'b0;
    assign o_frame_done = (state == S_OUT) && i_bit_ready && (cnt == LAST);
    assign o_busy       = (state != S_IDLE);

    // Predecessors of n are {n[K-3:0],x}; the input bit into n is its MSB. Ties keep p0.
    always_comb begin
        logic [K-2:0]    nst;
        logic [K-2:0]    p0;
        logic [K-2:0]    p1;
        logic [PM_W-1:0] m0;
        logic [PM_W-1:0] m1;
        dec = '0;
        for (int n = 0; n < NS; n++) begin
            nst = n[K-2:0];
            p0  = {nst[K-3:0], 1'b0};
            p1  = {nst[K-3:0], 1'b1};
            m0  = sat_add(pm[p0], bmetric({nst[K-2], p0}, i_sym));
            m1  = sat_add(pm[p1], bmetric({nst[K-2], p1}, i_sym));
            if (m1 < m0) begin
                pm_nxt[n] = m1;
                dec[n]    = 1'b1;
            end else begin
                pm_nxt[n] = m0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            tail_q   <= 1'b0;
            tb_state <= '0;
            best_pm  <= '0;
            for (int i = 0; i < NS; i++) pm[i] <= (i == 0) ? '0 : PM_INIT;
        end else begin
            case (state)
                S_IDLE, S_ACS: begin
                    if (sym_hs) begin
                        pm <= pm_nxt;
                        if (state == S_IDLE) tail_q <= i_tail_term;
                        if (cnt == LAST) begin
                            cnt      <= term ? FLEN : '0;
                            tb_state <= '0;
                            state    <= term ? S_TRACE : S_BEST;
                        end else begin
                            cnt   <= cnt + ONE;
                            state <= S_ACS;
                        end
                    end
                end
                S_BEST: begin
                    if (scan_take) begin
                        tb_state <= cnt_s;
                        best_pm  <= pm[cnt_s];
                    end
                    if (cnt == SLAST) begin
                        cnt   <= FLEN;
                        state <= S_TRACE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                S_TRACE: begin
                    if (cnt != '0) begin
                        tb_state <= {tb_state[K-3:0], surv[tr_t][tb_state]};
                        cnt      <= cnt - ONE;
                    end else begin
                        // PMs are reseeded here so the next frame starts from state 0.
                        for (int i = 0; i < NS; i++) pm[i] <= (i == 0) ? '0 : PM_INIT;
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (i_bit_ready) begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sym_hs) surv[cnt_t] <= dec;
        if (trace_step) out_buf[tr_t] <= tb_state[K-2];
    end
endmodule

// File: tb/tb_viterbi_frame_decoder.sv
// Directed bench: K=3 rate-1/2 frames of 6 symbols (table driven) and a rate-1/3 all-zero frame pair.
module tb_viterbi_frame_decoder;
    logic clk;
    logic rst;

    logic       a_vld, a_rdy, a_term, a_bvld, a_bit, a_brdy, a_done, a_busy;
    logic [1:0] a_sym;
    logic       b_vld, b_rdy, b_term, b_bvld, b_bit, b_brdy, b_done, b_busy;
    logic [2:0] b_sym;

    int errors = 0;
    int checks = 0;

    viterbi_frame_decoder #(
        .K(3), .N_OUT(2), .G0(3'b111), .G1(3'b101), .G2(3'b000), .FRAME_LEN(6), .PM_W(8)
    ) dut_a (
        .clk(clk), .rst(rst),
        .i_sym_valid(a_vld), .i_sym(a_sym), .o_sym_ready(a_rdy), .i_tail_term(a_term),
        .o_bit_valid(a_bvld), .o_bit(a_bit), .i_bit_ready(a_brdy),
        .o_frame_done(a_done), .o_busy(a_busy)
    );

    viterbi_frame_decoder #(
        .K(3), .N_OUT(3), .G0(3'b111), .G1(3'b101), .G2(3'b011), .FRAME_LEN(16), .PM_W(8)
    ) dut_b (
        .clk(clk), .rst(rst),
        .i_sym_valid(b_vld), .i_sym(b_sym), .o_sym_ready(b_rdy), .i_tail_term(b_term),
        .o_bit_valid(b_bvld), .o_bit(b_bit), .i_bit_ready(b_brdy),
        .o_frame_done(b_done), .o_busy(b_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] syms;      // symbol i at [2i+1:2i], bit0 = code bit 0
        logic        term;
        logic [5:0]  exp_bits;  // bit i = i-th decoded bit
        int          exp_lat;
        bit          gaps;
        bit          bp;
        int          abort_sym;
        int          abort_bit;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #1;
        check("rst_sym_ready", a_rdy, 0);
        check("rst_busy", a_busy, 0);
        check("rst_bit_valid", a_bvld, 0);
        check("rst_bit", a_bit, 0);
        check("rst_frame_done", a_done, 0);
        step();
        check("rst_ignores_valid", a_rdy, 0);
        step();
        a_vld  = 1'b0;
        a_brdy = 1'b0;
        rst    = 1'b1;
        step();
        check("post_rst_idle", a_busy, 0);
    endtask

    task automatic run_a(input vec_t v);
        int   lat, got, cyc, wc;
        logic held;
        bit   stalled;
        a_term = v.term;
        for (int i = 0; i < 6; i++) begin
            if (v.gaps) begin
                a_vld = 1'b0;
                repeat ($urandom_range(0, 2)) step();
            end
            a_vld = 1'b1;
            a_sym = v.syms[2*i +: 2];
            if (i == v.abort_sym) begin
                reset_pulse();
                return;
            end
            wc = 0;
            while (!a_rdy && wc < 50) begin
                step();
                wc++;
            end
            check("sym_ready", a_rdy, 1);
            if (i == 3) a_term = ~v.term;
            step();
        end
        a_vld = 1'b0;
        check("busy_after_frame", a_busy, 1);
        lat = 0;
        while (!a_bvld && lat < 100) begin
            step();
            lat++;
        end
        check("latency", lat, v.exp_lat);
        got = 0;
        cyc = 0;
        stalled = 0;
        held = 1'b0;
        while (got < 6 && cyc < 200) begin
            a_brdy = v.bp ? (cyc % 2 == 1) : 1'b1;
            #1;
            if (a_bvld && got == v.abort_bit) begin
                reset_pulse();
                return;
            end
            if (a_bvld) begin
                check("sym_ready_in_out", a_rdy, 0);
                if (stalled) check("bit_hold", a_bit, held);
                if (a_brdy) begin
                    check("bit", a_bit, v.exp_bits[got]);
                    check("frame_done", a_done, (got == 5) ? 1 : 0);
                    got++;
                    stalled = 0;
                end else begin
                    check("frame_done_stall", a_done, 0);
                    held    = a_bit;
                    stalled = 1;
                end
            end else begin
                check("bit_valid", a_bvld, 1);
            end
            step();
            cyc++;
        end
        a_brdy = 1'b0;
        check("bits_delivered", got, 6);
        check("idle_after_done", a_busy, 0);
    endtask

    task automatic run_b(input logic term, input int exp_lat);
        int lat, got, cyc;
        b_term = term;
        b_sym  = 3'b000;
        for (int i = 0; i < 16; i++) begin
            b_vld = 1'b1;
            lat = 0;
            while (!b_rdy && lat < 50) begin
                step();
                lat++;
            end
            check("b_sym_ready", b_rdy, 1);
            step();
        end
        b_vld = 1'b0;
        lat = 0;
        while (!b_bvld && lat < 100) begin
            step();
            lat++;
        end
        check("b_latency", lat, exp_lat);
        b_brdy = 1'b1;
        #1;
        got = 0;
        cyc = 0;
        while (got < 16 && cyc < 100) begin
            if (b_bvld) begin
                check("b_bit", b_bit, 0);
                check("b_frame_done", b_done, (got == 15) ? 1 : 0);
                got++;
            end else begin
                check("b_bit_valid", b_bvld, 1);
            end
            step();
            cyc++;
        end
        b_brdy = 1'b0;
        check("b_bits_delivered", got, 16);
        check("b_idle_after_done", b_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        //                syms               term  bits       lat gaps bp abort_sym abort_bit
        vecs[0] = '{12'b11_10_10_00_01_11, 1'b1, 6'b001101,  7, 0, 0, -1, -1};
        vecs[1] = '{12'b11_10_00_00_01_11, 1'b1, 6'b001101,  7, 0, 0, -1, -1};
        vecs[2] = '{12'b11_10_10_00_01_11, 1'b0, 6'b001101, 11, 0, 0, -1, -1};
        vecs[3] = '{12'b11_10_10_00_01_11, 1'b1, 6'b001101,  7, 1, 1, -1, -1};
        vecs[4] = '{12'b11_10_10_00_01_11, 1'b0, 6'b001101, 11, 1, 1, -1, -1};
        vecs[5] = '{12'b11_10_10_00_01_11, 1'b1, 6'b001101,  7, 0, 0,  3, -1};
        vecs[6] = '{12'b11_10_10_00_01_11, 1'b1, 6'b001101,  7, 0, 0, -1, -1};
        vecs[7] = '{12'b11_10_10_00_01_11, 1'b1, 6'b001101,  7, 0, 0, -1,  2};
        vecs[8] = '{12'b11_10_00_00_01_11, 1'b1, 6'b001101,  7, 1, 1, -1, -1};

        clk = 1'b0;
        rst = 1'b0;
        a_vld = 1'b1; a_sym = 2'b11; a_term = 1'b0; a_brdy = 1'b1;
        b_vld = 1'b0; b_sym = 3'b000; b_term = 1'b0; b_brdy = 1'b0;
        #3;
        check("reset_sym_ready", a_rdy, 0);
        check("reset_bit_valid", a_bvld, 0);
        check("reset_bit", a_bit, 0);
        check("reset_frame_done", a_done, 0);
        check("reset_busy", a_busy, 0);
        check("reset_b_sym_ready", b_rdy, 0);
        step();
        step();
        check("reset_ignores_valid", a_busy, 0);
        a_vld  = 1'b0;
        a_brdy = 1'b0;
        rst    = 1'b1;
        step();
        check("idle_sym_ready", a_rdy, 1);

        for (int v = 0; v < 9; v++) run_a(vecs[v]);

        run_b(1'b1, 17);
        run_b(1'b0, 21);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
